fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// ============================================================================
// Module   : fifo_wr_arbiter
// Brief    : Round-robin burst arbiter granting N requesters the write port of
//            one shared FIFO, with up to MAX_BURST words per grant.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ack,
    output logic [NUM_REQ-1:0]            grant,
    input  logic                          fifo_full,
    output logic                          fifo_write_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic                          busy,
    output logic                          burst_done
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0]   C_CNT_LAST = CNT_W'(MAX_BURST - 1);
    localparam logic [IDX_W-1:0]   C_LAST_RST = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] C_ONE      = NUM_REQ'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    state_t               r_state, w_state_next;
    logic [NUM_REQ-1:0]   r_grant, w_grant_next;
    logic [IDX_W-1:0]     r_gidx, w_gidx_next;
    logic [IDX_W-1:0]     r_last_id, w_last_next;
    logic [CNT_W-1:0]     r_cnt, w_cnt_next;
    logic                 r_burst_done, w_done_next;

    logic [DATA_WIDTH-1:0] w_slice [NUM_REQ];
    logic [IDX_W-1:0]      w_win_idx;
    logic                  w_win_valid;
    int                    w_scan_idx;
    logic                  w_req_g;
    logic                  w_busy;
    logic                  w_write;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
        assign w_slice[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan from the farthest offset down so the nearest requester after last_id wins.
    always_comb begin
        w_win_idx   = r_last_id;
        w_win_valid = 1'b0;
        w_scan_idx  = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            w_scan_idx = (int'(r_last_id) + i) % NUM_REQ;
            if (req[IDX_W'(w_scan_idx)]) begin
                w_win_idx   = IDX_W'(w_scan_idx);
                w_win_valid = 1'b1;
            end
        end
    end

    // Outputs are forced quiet during reset, even before the state register clears.
    assign w_busy  = (r_state == ST_BURST) && !reset;
    assign w_req_g = req[r_gidx];
    assign w_write = w_busy && w_req_g && !fifo_full;

    assign busy          = w_busy;
    assign fifo_write_en = w_write;
    assign req_ack       = w_write ? r_grant : '0;
    assign grant         = r_grant;
    assign fifo_din      = w_slice[r_gidx];
    assign burst_done    = r_burst_done;

    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant;
        w_gidx_next  = r_gidx;
        w_last_next  = r_last_id;
        w_cnt_next   = r_cnt;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_next = ST_BURST;
                    w_grant_next = C_ONE << w_win_idx;
                    w_gidx_next  = w_win_idx;
                    w_last_next  = w_win_idx;
                    w_cnt_next   = '0;
                end
            end
            ST_BURST: begin
                if (w_write) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                if ((w_write && (r_cnt == C_CNT_LAST)) || !w_req_g) begin
                    w_state_next = ST_IDLE;
                    w_grant_next = '0;
                    w_done_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_id    <= C_LAST_RST;
            r_cnt        <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_gidx       <= w_gidx_next;
            r_last_id    <= w_last_next;
            r_cnt        <= w_cnt_next;
            r_burst_done <= w_done_next;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ============================================================================
// Module   : tb_fifo_wr_arbiter
// Brief    : Directed, table-driven bench for fifo_wr_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_wr_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 32;
    localparam int MB    = 4;
    localparam int LIMIT = (NR - 1) * (MB + 1) + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]   req_ack;
    logic [NR-1:0]   grant;
    logic            fifo_full;
    logic            fifo_write_en;
    logic [DW-1:0]   fifo_din;
    logic            busy;
    logic            burst_done;

    int n_cmp  = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .grant        (grant),
        .fifo_full    (fifo_full),
        .fifo_write_en(fifo_write_en),
        .fifo_din     (fifo_din),
        .busy         (busy),
        .burst_done   (burst_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic [NR-1:0] rq;
        logic          full;
        logic [NR-1:0] e_grant;
        logic          e_wr;
        logic          e_busy;
        logic          e_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic [NR-1:0] q, logic f,
                                logic [NR-1:0] g, logic w, logic b, logic d);
        vec_t v;
        v.rst = r; v.rq = q; v.full = f;
        v.e_grant = g; v.e_wr = w; v.e_busy = b; v.e_done = d;
        vecs.push_back(v);
    endfunction

    function automatic int oh2idx(logic [NR-1:0] oh);
        int r = 0;
        for (int i = 0; i < NR; i++) if (oh[i]) r = i;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic drive(logic r, logic [NR-1:0] q, logic f);
        @(negedge clk);
        reset = r; req = q; fifo_full = f;
        #1;
    endtask

    task automatic set_default_data();
        for (int k = 0; k < NR; k++) req_data[k*DW +: DW] = 32'hA000_0000 + k;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1; req = '0; fifo_full = 1'b0;
        set_default_data();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NR-1:0] rq_s, last_ack, rq_r;
        logic          full_r, ok;
        int            wcnt [NR];
        int            w;

        reset = 1'b1; req = '0; fifo_full = 1'b0; req_data = '0;

        // Reset state, held with requests and data present.
        reset_dut();
        req = '1; #1;
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(burst_done), 0);
        chk("rst_wr", 32'(fifo_write_en), 0);
        chk("rst_ack", 32'(req_ack), 0);

        // All requesters held: four-word bursts in round-robin order.
        add(0, 4'hF, 0, 4'h0, 0, 0, 0);
        for (int b = 0; b < NR; b++) begin
            for (int k = 0; k < MB; k++) add(0, 4'hF, 0, NR'(1) << b, 1, 1, 0);
            add(0, 4'hF, 0, 4'h0, 0, 0, 1);
        end
        add(0, 4'hF, 0, 4'h1, 1, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rq, vecs[i].full);
            chk($sformatf("tbl%0d_grant", i), 32'(grant), 32'(vecs[i].e_grant));
            chk($sformatf("tbl%0d_wr", i), 32'(fifo_write_en), 32'(vecs[i].e_wr));
            chk($sformatf("tbl%0d_ack", i), 32'(req_ack),
                vecs[i].e_wr ? 32'(vecs[i].e_grant) : 32'h0);
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
            chk($sformatf("tbl%0d_done", i), 32'(burst_done), 32'(vecs[i].e_done));
            if (vecs[i].e_wr)
                chk($sformatf("tbl%0d_din", i), fifo_din,
                    32'hA000_0000 + 32'(oh2idx(vecs[i].e_grant)));
        end

        // Short burst ended by req drop; others toggle meanwhile; next search from 3.
        reset_dut();
        drive(0, 4'b0100, 0);
        chk("shortA_idle_grant", 32'(grant), 0);
        req_data[0 +: DW] = 32'hDEAD_0000; req_data[3*DW +: DW] = 32'hBEEF_0003;
        drive(0, 4'b1101, 0);
        chk("shortA_w1", {27'd0, fifo_write_en, req_ack}, {27'd0, 1'b1, 4'b0100});
        chk("shortA_din1", fifo_din, 32'hA000_0002);
        req_data[DW +: DW] = 32'h1234_5678;
        drive(0, 4'b0110, 0);
        chk("shortA_w2", {27'd0, fifo_write_en, req_ack}, {27'd0, 1'b1, 4'b0100});
        chk("shortA_din2", fifo_din, 32'hA000_0002);
        drive(0, 4'b0000, 0);
        chk("shortA_drop", {30'd0, busy, fifo_write_en}, {30'd0, 1'b1, 1'b0});
        drive(0, 4'b0000, 0);
        chk("shortA_done", {26'd0, busy, burst_done, grant}, {26'd0, 1'b0, 1'b1, 4'b0000});
        set_default_data();
        drive(0, 4'b1011, 0);
        chk("shortA_idle2", {26'd0, busy, burst_done, grant}, 32'h0);
        drive(0, 4'b1011, 0);
        chk("shortA_next_grant", 32'(grant), 32'h8);
        chk("shortA_next_din", fifo_din, 32'hA000_0003);

        // Stall under fifo_full: no writes for 5 cycles, then 3 more in order.
        reset_dut();
        w = 0;
        drive(0, 4'b0001, 0);
        foreach (rq_r[i]) rq_r[i] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            full_r = (i >= 1 && i <= 5);
            req_data[0 +: DW] = 32'h1000_0000 + 32'(w);
            drive(0, 4'b0001, full_r);
            chk($sformatf("stall%0d_wr", i), 32'(fifo_write_en), 32'(!full_r));
            chk($sformatf("stall%0d_ack", i), 32'(req_ack), full_r ? 32'h0 : 32'h1);
            chk($sformatf("stall%0d_busy", i), 32'(busy), 32'h1);
            if (fifo_write_en) begin
                chk($sformatf("stall%0d_din", i), fifo_din, 32'h1000_0000 + 32'(w));
                w++;
            end
        end
        chk("stall_words", 32'(w), 32'(MB));
        drive(0, 4'b0001, 0);
        chk("stall_exit", {30'd0, busy, burst_done}, {30'd0, 1'b0, 1'b1});

        // Reset on the 2nd write: burst aborted silently, requester 0 wins again.
        reset_dut();
        drive(0, 4'b0011, 0);
        drive(0, 4'b0011, 0);
        chk("abort_w1", {27'd0, fifo_write_en, grant}, {27'd0, 1'b1, 4'b0001});
        drive(1, 4'b0011, 0);
        chk("abort_rst_out", {26'd0, busy, fifo_write_en, req_ack}, 32'h0);
        drive(0, 4'b0011, 0);
        chk("abort_after", {26'd0, busy, burst_done, grant}, 32'h0);
        drive(0, 4'b0011, 0);
        chk("abort_regrant", {27'd0, busy, grant}, {27'd0, 1'b1, 4'b0001});

        // Random traffic: structural invariants every cycle.
        reset_dut();
        for (int i = 0; i < 2000; i++) begin
            rq_r   = NR'($urandom);
            full_r = ($urandom_range(0, 3) == 0);
            drive(0, rq_r, full_r);
            ok = $onehot0(grant) && $onehot0(req_ack) && !(fifo_write_en && fifo_full)
                 && (req_ack == (fifo_write_en ? grant : '0)) && (!fifo_write_en || busy);
            chk($sformatf("rand%0d_invariants", i), 32'(ok), 32'h1);
        end

        // FIFO never full, requests held until acked: bounded waiting.
        reset_dut();
        rq_s = '0; last_ack = '0;
        foreach (wcnt[k]) wcnt[k] = 0;
        for (int i = 0; i < 2000; i++) begin
            for (int k = 0; k < NR; k++)
                if (!(rq_s[k] && !last_ack[k])) rq_s[k] = ($urandom_range(0, 3) != 0);
            drive(0, rq_s, 0);
            ok = $onehot0(req_ack);
            for (int k = 0; k < NR; k++) begin
                if (rq_s[k] && !req_ack[k]) wcnt[k]++;
                else wcnt[k] = 0;
                if (wcnt[k] > LIMIT) ok = 1'b0;
            end
            last_ack = req_ack;
            chk($sformatf("starve%0d", i), 32'(ok), 32'h1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
